// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: issues sequential word reads to instruction
// memory with a bounded number of requests in flight, buffers the in-order
// responses in a small FIFO tagged with their pc, and hands {pc, instr} to
// decode over a valid/ready handshake. A redirect flushes the FIFO, restarts
// fetch at the new target and marks every unanswered request as stale so
// its response is thrown away when it eventually returns.
module rv_fetch_queue #(
  parameter int XLEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          reset_pc,
  output logic                     imem_req_valid,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  output logic [XLEN-1:0]          inst_data,
  output logic [XLEN-1:0]          inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_spurious
);

  // Pointer width, occupancy width and a counter width wide enough to hold
  // occupancy plus outstanding requests without overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = PW + 2;

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   fetchPc_q, fetchPc_d;
  logic [XLEN-1:0]   rspPc_q, rspPc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     dropCnt_q, dropCnt_d;
  logic [OW-1:0]     count_q, count_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic              errSpurious_q;
  logic [XLEN-1:0]   dataMem_q [DEPTH];
  logic [XLEN-1:0]   pcMem_q [DEPTH];

  logic [XLEN-1:0]   redirectAligned;
  logic [XLEN-1:0]   bootAligned;
  logic [CW-1:0]     live;
  logic              hasCredit;
  logic              fire;
  logic              rspSpurious;
  logic              rspLive;
  logic              rspDropped;
  logic              pushEn;
  logic              popEn;
  logic              restart;

  assign redirectAligned = redirect_pc & ~XLEN'(3);
  assign bootAligned     = reset_pc & ~XLEN'(3);

  // Requests that will still produce a FIFO entry; stale ones do not need
  // buffer space, but they still hold a slot of the outstanding limit.
  assign live      = inflight_q - dropCnt_q;
  assign hasCredit = ((CW'(count_q) + live) < CW'(DEPTH)) &&
                     (inflight_q < CW'(MAX_OUTSTANDING));

  assign imem_req_valid = (state_q == RUN) && !redirect_valid && hasCredit;
  assign imem_req_addr  = fetchPc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is ignored entirely; otherwise it
  // retires one request and is either dropped as stale or buffered.
  assign rspSpurious = imem_rsp_valid && (inflight_q == '0);
  assign rspLive     = imem_rsp_valid && !rspSpurious;
  assign rspDropped  = rspLive && (dropCnt_q != '0);
  assign pushEn      = rspLive && !rspDropped && !redirect_valid;
  assign popEn       = inst_valid && inst_ready && !redirect_valid;

  // Leaving BOOT and taking a redirect both reload the fetch stream.
  assign restart = redirect_valid || (state_q == BOOT);

  assign inst_valid   = (count_q != '0);
  assign inst_data    = inst_valid ? dataMem_q[rdPtr_q] : '0;
  assign inst_pc      = inst_valid ? pcMem_q[rdPtr_q] : '0;
  assign occupancy    = count_q;
  assign err_spurious = errSpurious_q;

  // Next-state for the fetch pointer, credit counters and FIFO bookkeeping.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    rspPc_d    = rspPc_q;
    dropCnt_d  = dropCnt_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    inflight_d = inflight_q + CW'(fire) - CW'(rspLive);
    count_d    = count_q + OW'(pushEn) - OW'(popEn);

    if (fire) begin
      fetchPc_d = fetchPc_q + XLEN'(4);
    end
    if (rspDropped) begin
      dropCnt_d = dropCnt_q - CW'(1);
    end
    if (pushEn) begin
      wrPtr_d = wrPtr_q + PW'(1);
      rspPc_d = rspPc_q + XLEN'(4);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    if (restart) begin
      fetchPc_d = redirect_valid ? redirectAligned : bootAligned;
      rspPc_d   = fetchPc_d;
      dropCnt_d = inflight_q - CW'(rspLive);
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end
  end

  // Control state, counters and sticky error flag; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetchPc_q     <= '0;
      rspPc_q       <= '0;
      inflight_q    <= '0;
      dropCnt_q     <= '0;
      count_q       <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      errSpurious_q <= 1'b0;
    end else begin
      if (state_q == BOOT) begin
        state_q <= RUN;
      end
      fetchPc_q  <= fetchPc_d;
      rspPc_q    <= rspPc_d;
      inflight_q <= inflight_d;
      dropCnt_q  <= dropCnt_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      if (rspSpurious) begin
        errSpurious_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by
  // inst_valid. The credit rule guarantees a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      assert (count_q != OW'(DEPTH));
      dataMem_q[wrPtr_q] <= imem_rsp_data;
      pcMem_q[wrPtr_q]   <= rspPc_q;
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue. The reference model thinks in terms of the
// instruction stream: every request is tagged with the fetch epoch it was
// issued in, a redirect starts a new epoch, and only responses from the
// current epoch become FIFO entries, whose data is addr ^ KEY.
module tb_rv_fetch_queue;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [XLEN-1:0]     reset_pc = '0;
  logic                imem_req_valid;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_req_ready = 1'b0;
  logic                imem_rsp_valid = 1'b0;
  logic [XLEN-1:0]     imem_rsp_data = '0;
  logic                redirect_valid = 1'b0;
  logic [XLEN-1:0]     redirect_pc = '0;
  logic                inst_valid;
  logic [XLEN-1:0]     inst_data;
  logic [XLEN-1:0]     inst_pc;
  logic                inst_ready = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
  logic                err_spurious;

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  req_t        outQ[$];
  logic [31:0] fifoQ[$];
  bit          bootModel;
  logic [31:0] nextFetch;
  int          epoch;
  bit          errModel;

  int total = 0;
  int bad = 0;
  int dutFires = 0;

  rv_fetch_queue #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reset_pc(reset_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .occupancy(occupancy),
    .err_spurious(err_spurious)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the stream model across the rising edge.
  // rspMode: 0 no response, 1 answer oldest request if any, 2 always drive.
  task automatic applyStimulus(input bit memRdy, input int rspMode, input bit decRdy,
                               input bit redir, input logic [31:0] rpc);
    bit          expReq;
    bit          fireM;
    bit          doPush;
    int          live;
    logic [31:0] pushPc;
    req_t        r;
    imem_req_ready = memRdy;
    inst_ready     = decRdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rspMode == 1 && outQ.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = outQ[0].addr ^ KEY;
    end else if (rspMode == 2) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = (outQ.size() > 0) ? (outQ[0].addr ^ KEY) : $urandom();
    end
    live = 0;
    foreach (outQ[i]) if (outQ[i].ep == epoch) live++;
    expReq = !bootModel && !redir && ((fifoQ.size() + live) < DEPTH) &&
             (outQ.size() < MAX_OUT);

    @(negedge clk);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(expReq));
    if (expReq) checkOutput("req_addr", imem_req_addr, nextFetch);
    checkOutput("inst_valid", 32'(inst_valid), 32'(fifoQ.size() != 0));
    if (fifoQ.size() != 0) begin
      checkOutput("inst_pc", inst_pc, fifoQ[0]);
      checkOutput("inst_data", inst_data, fifoQ[0] ^ KEY);
    end
    checkOutput("occupancy", 32'(occupancy), 32'(fifoQ.size()));
    checkOutput("err_spurious", 32'(err_spurious), 32'(errModel));
    if (imem_req_valid && memRdy) dutFires++;

    fireM  = expReq && memRdy;
    doPush = 1'b0;
    pushPc = '0;
    if (imem_rsp_valid) begin
      if (outQ.size() == 0) begin
        errModel = 1'b1;
      end else begin
        r = outQ.pop_front();
        if (!redir && r.ep == epoch) begin
          doPush = 1'b1;
          pushPc = r.addr;
        end
      end
    end
    if (!redir && fifoQ.size() != 0 && decRdy) void'(fifoQ.pop_front());
    if (doPush) fifoQ.push_back(pushPc);
    if (redir) begin
      epoch++;
      fifoQ.delete();
      nextFetch = {rpc[31:2], 2'b00};
      bootModel = 1'b0;
    end else if (bootModel) begin
      nextFetch = {reset_pc[31:2], 2'b00};
      bootModel = 1'b0;
    end
    if (fireM) begin
      outQ.push_back('{addr: nextFetch, ep: epoch});
      nextFetch = nextFetch + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the outputs clear immediately, and
  // releases it just after the next rising edge with a new boot address.
  task automatic doReset(input logic [31:0] pc);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'd0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst_data", inst_data, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_err", 32'(err_spurious), 32'd0);
    outQ.delete();
    fifoQ.delete();
    bootModel      = 1'b1;
    nextFetch      = '0;
    epoch++;
    errModel       = 1'b0;
    reset_pc       = pc;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Lets every outstanding response return and decode empty the FIFO.
  task automatic drain();
    for (int i = 0; i < 30 && (outQ.size() != 0 || fifoQ.size() != 0); i++)
      applyStimulus(1'b0, 1, 1'b1, 1'b0, '0);
    checkOutput("drain_occupancy", 32'(occupancy), 32'd0);
  endtask

  initial begin
    int fires0;
    epoch = 0;

    // Boot at 0x1000 and stream with a 1-cycle memory.
    doReset(32'h0000_1000);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    checkOutput("boot_addr", imem_req_addr, 32'h0000_1000);
    checkOutput("boot_req_valid", 32'(imem_req_valid), 32'd1);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    fires0 = dutFires;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    checkOutput("steady_fires", 32'(dutFires - fires0), 32'd8);

    // Backpressure from decode fills the FIFO and stops fetching.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1, 1'b0, 1'b0, '0);
    checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
    checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    drain();

    // Redirect with two requests in flight; both responses are stale.
    applyStimulus(1'b1, 0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 0, 1'b1, 1'b1, 32'h0000_2002);
    checkOutput("redir_addr", imem_req_addr, 32'h0000_2000);
    checkOutput("redir_occupancy", 32'(occupancy), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    drain();

    // Redirect coinciding with a response and a pop.
    applyStimulus(1'b1, 0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 32'h0000_5000);
    checkOutput("coinc_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("coinc_occupancy", 32'(occupancy), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    drain();

    // Address wrap at the top of memory.
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 0, 1'b1, 1'b0, '0);
    checkOutput("wrap_addr1", imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    drain();

    // Spurious response sets a sticky error.
    applyStimulus(1'b0, 2, 1'b1, 1'b0, '0);
    checkOutput("spurious_set", 32'(err_spurious), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    checkOutput("spurious_sticky", 32'(err_spurious), 32'd1);
    drain();

    // Async reset with three buffered entries, then reboot at 0x400; a late
    // response from before the reset is spurious.
    for (int i = 0; i < 20 && fifoQ.size() < 3; i++)
      applyStimulus(1'b1, 1, 1'b0, 1'b0, '0);
    checkOutput("fill3_occupancy", 32'(occupancy), 32'd3);
    doReset(32'h0000_0400);
    applyStimulus(1'b0, 2, 1'b1, 1'b0, '0);
    checkOutput("reboot_addr", imem_req_addr, 32'h0000_0400);
    checkOutput("reboot_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("late_rsp_err", 32'(err_spurious), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);
    drain();

    // Redirect in the boot cycle overrides the boot address.
    doReset(32'h0000_0800);
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 32'h0000_3006);
    checkOutput("boot_redir_addr", imem_req_addr, 32'h0000_3004);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0, '0);

    // Randomized traffic with occasional redirects, some near the wrap point.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom());
      applyStimulus($urandom_range(0, 3) != 0, ($urandom_range(0, 2) != 0) ? 1 : 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
